// File: rtl/iob_rr_merge_pkg.sv
// Shared constants and helpers for the IOb many-to-one merger.
// Request layout  : {valid, address, wdata, wstrb}  (valid is the MSB)
// Response layout : {rdata, ready}                  (ready is the LSB)
package iob_rr_merge_pkg;

  localparam int IOB_ADDR_W = 32;
  localparam int IOB_DATA_W = 32;

  // FSM encoding
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // Width of one packed request slice
  function automatic int req_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w + data_w / 8;
  endfunction

  // Width of one packed response slice
  function automatic int resp_w(input int data_w);
    return data_w + 1;
  endfunction

endpackage

// File: rtl/iob_rr_arbiter.sv
// Combinational arbiter for the IOb merger.
// Default build: round-robin, search starts at ptr+1 and wraps.
// With IOB_MERGE_FIXED_PRIO_EN defined: lowest eligible index wins, ptr ignored.
// A master flagged in `exclude` never wins (the one completing this cycle).
module iob_rr_arbiter
  import iob_rr_merge_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]          req,
  input  logic [N-1:0]          exclude,
  input  logic [$clog2(N)-1:0]  ptr,
  output logic [$clog2(N)-1:0]  win,
  output logic                  any
);

  localparam int SEL_W = $clog2(N);

  logic [N-1:0] eligible;

  for (genvar gi = 0; gi < N; gi++) begin : g_elig
    assign eligible[gi] = req[gi] & ~exclude[gi];
  end

`ifdef IOB_MERGE_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  // Scan from the highest index down so the lowest eligible index is written last
  always_comb begin
    win = '0;
    any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (eligible[k]) begin
        win = SEL_W'(k);
        any = 1'b1;
      end
    end
  end
`else
  int               idx;
  logic [SEL_W-1:0] idx_sel;

  // Scan the rotated order backwards so the first candidate after ptr is written last
  always_comb begin
    win     = '0;
    any     = 1'b0;
    idx     = 0;
    idx_sel = '0;
    for (int k = N; k >= 1; k--) begin
      idx     = (int'(ptr) + k) % N;
      idx_sel = SEL_W'(idx);
      if (eligible[idx_sel]) begin
        win = idx_sel;
        any = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/iob_rr_merge.sv
// IOb native bus merger: N_MASTERS request buses onto one slave bus.
// The granted master's request is forwarded; the slave's ready is routed
// back only to that master while rdata is broadcast to every slice.
// Optional macro IOB_MERGE_FIXED_PRIO_EN switches the arbiter to fixed priority.
module iob_rr_merge
  import iob_rr_merge_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = IOB_ADDR_W,
  parameter int DATA_W    = IOB_DATA_W
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [N_MASTERS*req_w(ADDR_W, DATA_W)-1:0]    m_req,
  output logic [N_MASTERS*resp_w(DATA_W)-1:0]           m_resp,
  output logic [req_w(ADDR_W, DATA_W)-1:0]              s_req,
  input  logic [resp_w(DATA_W)-1:0]                     s_resp,
  output logic [$clog2(N_MASTERS)-1:0]                  sel,
  output logic                                          busy
);

  localparam int REQ_W  = req_w(ADDR_W, DATA_W);
  localparam int RESP_W = resp_w(DATA_W);
  localparam int SEL_W  = $clog2(N_MASTERS);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_MASTERS - 1);

  logic [0:0]           state_reg, state_next;
  logic [SEL_W-1:0]     sel_reg, sel_next;
  logic [SEL_W-1:0]     last_grant_reg, last_grant_next;

  logic [REQ_W-1:0]     req_arr [N_MASTERS];
  logic [N_MASTERS-1:0] valid_vec;
  logic [N_MASTERS-1:0] exclude_vec;
  logic [SEL_W-1:0]     win_idx;
  logic                 win_any;

  logic                 s_ready;
  logic [DATA_W-1:0]    s_rdata;
  logic                 in_busy;

  assign s_ready = s_resp[0];
  assign s_rdata = s_resp[RESP_W-1 -: DATA_W];
  assign in_busy = (state_reg == ST_BUSY);

  // Per-master unpacking, exclusion of the completing master, response demux.
  // ready is masked during rst so a slave ready coinciding with reset is dropped.
  for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_master
    assign req_arr[gi]     = m_req[gi*REQ_W +: REQ_W];
    assign valid_vec[gi]   = req_arr[gi][REQ_W-1];
    assign exclude_vec[gi] = in_busy && s_ready && (sel_reg == SEL_W'(gi));
    assign m_resp[gi*RESP_W +: RESP_W] =
      {s_rdata, in_busy && s_ready && !rst && (sel_reg == SEL_W'(gi))};
  end

  iob_rr_arbiter #(
    .N (N_MASTERS)
  ) u_arbiter (
    .req     (valid_vec),
    .exclude (exclude_vec),
    .ptr     (last_grant_reg),
    .win     (win_idx),
    .any     (win_any)
  );

  // Arbitrate when idle or when the current transfer completes; sel keeps the last grant
  always_comb begin
    state_next      = state_reg;
    sel_next        = sel_reg;
    last_grant_next = last_grant_reg;
    if (!in_busy || s_ready) begin
      if (win_any) begin
        state_next      = ST_BUSY;
        sel_next        = win_idx;
        last_grant_next = win_idx;
      end else begin
        state_next      = ST_IDLE;
      end
    end
  end

  // Grant and pointer registers; reset makes master 0 the first round-robin winner
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      sel_reg        <= '0;
      last_grant_reg <= LAST_IDX;
    end else begin
      state_reg      <= state_next;
      sel_reg        <= sel_next;
      last_grant_reg <= last_grant_next;
    end
  end

  // Forward only the granted request; nothing reaches the slave without a grant
  always_comb begin
    s_req = '0;
    if (in_busy) begin
      s_req = req_arr[sel_reg];
    end
  end

  assign busy = in_busy;
  assign sel  = sel_reg;

endmodule
